// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-stage control, instruction-memory and decode handshake signals
interface fetch_ctrl_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        resume_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        halted_o;
  logic        trap_o;
  modport master (
    input  redirect_i, redirect_pc_i, halt_i, resume_i, imem_rdata_i, id_ready_i,
    output imem_addr_o, id_valid_o, id_instr_o, id_pc_o, halted_o, trap_o
  );
  modport slave (
    output redirect_i, redirect_pc_i, halt_i, resume_i, imem_rdata_i, id_ready_i,
    input  imem_addr_o, id_valid_o, id_instr_o, id_pc_o, halted_o, trap_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and fetch register; FETCH_CTRL_ALIGN_TRAP_EN enables misaligned-redirect trap
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst_n,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
`ifdef FETCH_CTRL_ALIGN_TRAP_EN
    , TRAP
`endif
  } state_t;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] id_pc;
  logic        halted;
  logic        trap;
`ifdef FETCH_CTRL_ALIGN_TRAP_EN
  logic        mis;
  assign mis = |bus.redirect_pc_i[1:0];
`endif
  assign tgt             = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign bus.imem_addr_o = pc;
  assign bus.id_valid_o  = valid;
  assign bus.id_instr_o  = instr;
  assign bus.id_pc_o     = id_pc;
  assign bus.halted_o    = halted;
  assign bus.trap_o      = trap;
`ifndef FETCH_CTRL_ALIGN_TRAP_EN
  assign trap = 1'b0;
`endif
  // state machine: redirect > halt > stall > fetch in RUN; later assignments override earlier ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      valid  <= 1'b0;
      instr  <= 32'h0000_0013;
      id_pc  <= 32'h0000_0000;
      halted <= 1'b0;
`ifdef FETCH_CTRL_ALIGN_TRAP_EN
      trap   <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.redirect_i) begin
            valid <= 1'b0;
`ifdef FETCH_CTRL_ALIGN_TRAP_EN
            if (mis) begin
              state  <= TRAP;
              halted <= 1'b1;
              trap   <= 1'b1;
            end else
`endif
            pc <= tgt;
          end else if (bus.halt_i) begin
            valid  <= 1'b0;
            halted <= 1'b1;
            state  <= HALT;
          end else if (!(valid && !bus.id_ready_i)) begin
            instr <= bus.imem_rdata_i;
            id_pc <= pc;
            valid <= 1'b1;
            pc    <= pc + 32'd4;
          end
        end
        HALT: begin
          valid <= 1'b0;
          if (bus.resume_i) begin
            state  <= RUN;
            halted <= 1'b0;
          end
          if (bus.redirect_i) begin
`ifdef FETCH_CTRL_ALIGN_TRAP_EN
            if (mis) begin
              state  <= TRAP;
              halted <= 1'b1;
              trap   <= 1'b1;
            end else
`endif
            pc <= tgt;
          end
        end
        default: valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed test of fetch_ctrl with a word-per-address instruction memory
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  fetch_ctrl_if bus ();
  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata_i = ~bus.imem_addr_o;
  typedef struct {
    int          rd;
    logic [31:0] rpc;
    int          hl;
    int          rs;
    int          rdy;
    int          v;
    logic [31:0] pc;
    logic [31:0] addr;
    int          h;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input int rd, input logic [31:0] rpc, input int hl, input int rs, input int rdy,
                     input int v, input logic [31:0] pc, input logic [31:0] addr, input int h);
    vec_t t;
    t = '{rd: rd, rpc: rpc, hl: hl, rs: rs, rdy: rdy, v: v, pc: pc, addr: addr, h: h};
    vecs.push_back(t);
  endtask
  task automatic drive(input int rd, input logic [31:0] rpc, input int hl, input int rs, input int rdy);
    bus.redirect_i    = rd[0];
    bus.redirect_pc_i = rpc;
    bus.halt_i        = hl[0];
    bus.resume_i      = rs[0];
    bus.id_ready_i    = rdy[0];
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(bus.id_valid_o), 32'd0);
    chk({tag, "_instr"}, bus.id_instr_o, 32'h0000_0013);
    chk({tag, "_idpc"}, bus.id_pc_o, 32'd0);
    chk({tag, "_addr"}, bus.imem_addr_o, 32'd0);
    chk({tag, "_halted"}, 32'(bus.halted_o), 32'd0);
    chk({tag, "_trap"}, 32'(bus.trap_o), 32'd0);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h4, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h4, 32'h8, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h8, 32'hC, 0);
    add(0, 32'h0, 0, 0, 0, 1, 32'h8, 32'hC, 0);
    add(0, 32'h0, 0, 0, 0, 1, 32'h8, 32'hC, 0);
    add(0, 32'h0, 0, 0, 0, 1, 32'h8, 32'hC, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'hC, 32'h10, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h10, 32'h14, 0);
    add(1, 32'h40, 0, 0, 1, 0, 32'h0, 32'h40, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h40, 32'h44, 0);
    add(1, 32'h20, 0, 0, 1, 0, 32'h0, 32'h20, 0);
    add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h20, 1);
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h20, 1);
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h20, 1);
    add(0, 32'h0, 0, 1, 1, 0, 32'h0, 32'h20, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h20, 32'h24, 0);
    add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h24, 1);
    add(1, 32'h80, 0, 1, 1, 0, 32'h0, 32'h80, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h80, 32'h84, 0);
    add(1, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h4, 0);
    add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h4, 1);
    add(1, 32'h100, 0, 0, 1, 0, 32'h0, 32'h100, 1);
    add(0, 32'h0, 0, 1, 1, 0, 32'h0, 32'h100, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h100, 32'h104, 0);
    add(1, 32'h200, 1, 0, 1, 0, 32'h0, 32'h200, 0);
    add(0, 32'h0, 0, 0, 1, 1, 32'h200, 32'h204, 0);
    add(0, 32'h0, 0, 0, 0, 1, 32'h200, 32'h204, 0);
    add(1, 32'h300, 0, 0, 0, 0, 32'h0, 32'h300, 0);
    add(0, 32'h0, 0, 0, 0, 1, 32'h300, 32'h304, 0);
    drive(0, 32'h0, 0, 0, 1);
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].rpc, vecs[i].hl, vecs[i].rs, vecs[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.id_valid_o), 32'(vecs[i].v));
      chk($sformatf("v%0d_addr", i), bus.imem_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_halted", i), 32'(bus.halted_o), 32'(vecs[i].h));
      chk($sformatf("v%0d_trap", i), 32'(bus.trap_o), 32'd0);
      if (vecs[i].v != 0) begin
        chk($sformatf("v%0d_idpc", i), bus.id_pc_o, vecs[i].pc);
        chk($sformatf("v%0d_instr", i), bus.id_instr_o, ~vecs[i].pc);
      end
    end
    drive(1, 32'h42, 0, 0, 1);
    step();
`ifdef FETCH_CTRL_ALIGN_TRAP_EN
    chk("trap_set", 32'(bus.trap_o), 32'd1);
    chk("trap_halted", 32'(bus.halted_o), 32'd1);
    chk("trap_valid", 32'(bus.id_valid_o), 32'd0);
    chk("trap_addr", bus.imem_addr_o, 32'h304);
    drive(0, 32'h0, 0, 1, 1);
    step();
    step();
    chk("trap_resume_trap", 32'(bus.trap_o), 32'd1);
    chk("trap_resume_halted", 32'(bus.halted_o), 32'd1);
    chk("trap_resume_valid", 32'(bus.id_valid_o), 32'd0);
`else
    chk("mis_valid", 32'(bus.id_valid_o), 32'd0);
    chk("mis_addr", bus.imem_addr_o, 32'h40);
    chk("mis_trap", 32'(bus.trap_o), 32'd0);
    drive(0, 32'h0, 0, 0, 1);
    step();
    chk("mis_fetch_valid", 32'(bus.id_valid_o), 32'd1);
    chk("mis_fetch_idpc", bus.id_pc_o, 32'h40);
    chk("mis_fetch_instr", bus.id_instr_o, ~32'h40);
    step();
    chk("mis_next_idpc", bus.id_pc_o, 32'h44);
`endif
    drive(0, 32'h0, 0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    step();
    chk("boot_valid", 32'(bus.id_valid_o), 32'd0);
    step();
    chk("first_valid", 32'(bus.id_valid_o), 32'd1);
    chk("first_idpc", bus.id_pc_o, 32'h0);
    chk("first_instr", bus.id_instr_o, ~32'h0);
    chk("first_addr", bus.imem_addr_o, 32'h4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
